// File: rtl/ex_wb_regfile_if.sv
// EX/WB boundary bundle: EX result in, read/forward ports and WB latch out.
// Optional Retire_Cnt when EX_WB_RETIRE_CNT_EN is defined.
interface ex_wb_regfile_if #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3
);
   logic              EX_Valid;
   logic              EX_RegWrite;
   logic [REG_AW-1:0] EX_Write_Reg;
   logic [DATA_W-1:0] EX_Result;
   logic              Stall;
   logic              Flush;
   logic [REG_AW-1:0] Read_Reg;
   logic [DATA_W-1:0] Read_Data;
   logic [REG_AW-1:0] Fwd_Reg;
   logic              Fwd_Hit;
   logic [DATA_W-1:0] Fwd_Data;
   logic              WB_Valid;
   logic [REG_AW-1:0] WB_Write_Reg;
   logic [DATA_W-1:0] WB_Write_Data;
`ifdef EX_WB_RETIRE_CNT_EN
   logic [15:0]       Retire_Cnt;

   modport master (
      output EX_Valid, EX_RegWrite, EX_Write_Reg, EX_Result,
      output Stall, Flush, Read_Reg, Fwd_Reg,
      input  Read_Data, Fwd_Hit, Fwd_Data,
      input  WB_Valid, WB_Write_Reg, WB_Write_Data, Retire_Cnt
   );

   modport slave (
      input  EX_Valid, EX_RegWrite, EX_Write_Reg, EX_Result,
      input  Stall, Flush, Read_Reg, Fwd_Reg,
      output Read_Data, Fwd_Hit, Fwd_Data,
      output WB_Valid, WB_Write_Reg, WB_Write_Data, Retire_Cnt
   );
`else
   modport master (
      output EX_Valid, EX_RegWrite, EX_Write_Reg, EX_Result,
      output Stall, Flush, Read_Reg, Fwd_Reg,
      input  Read_Data, Fwd_Hit, Fwd_Data,
      input  WB_Valid, WB_Write_Reg, WB_Write_Data
   );

   modport slave (
      input  EX_Valid, EX_RegWrite, EX_Write_Reg, EX_Result,
      input  Stall, Flush, Read_Reg, Fwd_Reg,
      output Read_Data, Fwd_Hit, Fwd_Data,
      output WB_Valid, WB_Write_Reg, WB_Write_Data
   );
`endif
endinterface

// File: rtl/ex_wb_regfile.sv
// EX/WB pipeline latch plus 8x8 register file with bypassed read port.
// Optional retire counter enabled by EX_WB_RETIRE_CNT_EN.
module ex_wb_regfile #(
   parameter int DATA_W   = 8,
   parameter int REG_AW   = 3,
   parameter int NUM_REGS = 2**REG_AW
) (
   input logic            Clk,
   input logic            Reset,
   ex_wb_regfile_if.slave bus
);
   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_latch_t;

   wb_latch_t         wb;
   logic [DATA_W-1:0] rf [NUM_REGS];
   logic              wb_we;
   logic              advance;
   logic [DATA_W-1:0] rd_data;

   // Flush overrides Stall: the pending WB instruction still drains.
   assign advance = bus.Flush | ~bus.Stall;
   assign wb_we   = wb.valid & wb.reg_write & (wb.rd != '0);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wb <= '0;
      end else if (bus.Flush) begin
         wb <= '{1'b0, 1'b0, bus.EX_Write_Reg, bus.EX_Result};
      end else if (!bus.Stall) begin
         wb <= '{bus.EX_Valid,
                 bus.EX_Valid & bus.EX_RegWrite,
                 bus.EX_Write_Reg,
                 bus.EX_Result};
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_we && advance) begin
         rf[wb.rd] <= wb.data;
      end
   end

   always_comb begin
      rd_data = rf[bus.Read_Reg];
      if (bus.Read_Reg == '0) begin
         rd_data = '0;
      end else if (wb_we && (wb.rd == bus.Read_Reg)) begin
         rd_data = wb.data;
      end
   end

   assign bus.Read_Data     = rd_data;
   assign bus.Fwd_Hit       = wb_we & (wb.rd == bus.Fwd_Reg);
   assign bus.Fwd_Data      = wb.data;
   assign bus.WB_Valid      = wb.valid;
   assign bus.WB_Write_Reg  = wb.rd;
   assign bus.WB_Write_Data = wb.data;

`ifdef EX_WB_RETIRE_CNT_EN
   logic [15:0] retire_cnt;

   // Counts every valid instruction leaving the latch; saturates.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         retire_cnt <= '0;
      end else if (wb.valid && advance && (retire_cnt != 16'hFFFF)) begin
         retire_cnt <= retire_cnt + 16'd1;
      end
   end

   assign bus.Retire_Cnt = retire_cnt;
`endif
endmodule

// File: tb/tb_ex_wb_regfile.sv
// Directed bench for ex_wb_regfile: latency, r0, stall, flush, bypass, reset.
// Retire counter checks compile in only with EX_WB_RETIRE_CNT_EN.
module tb_ex_wb_regfile;
   logic Clk;
   logic Reset;
   int   total;
   int   fails;

   ex_wb_regfile_if #(.DATA_W(8), .REG_AW(3)) bus ();

   ex_wb_regfile #(.DATA_W(8), .REG_AW(3), .NUM_REGS(8)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ex(input logic v, input logic rw, input logic [2:0] rd,
                     input logic [7:0] res);
      bus.EX_Valid     = v;
      bus.EX_RegWrite  = rw;
      bus.EX_Write_Reg = rd;
      bus.EX_Result    = res;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] exp);
`ifdef EX_WB_RETIRE_CNT_EN
      chk(tag, bus.Retire_Cnt, exp);
`else
      if (tag.len() < 0) $display("%0h", exp);
`endif
   endtask

   initial begin
      total = 0;
      fails = 0;
      Reset = 1'b1;
      ex(0, 0, 0, 8'h00);
      bus.Stall    = 1'b0;
      bus.Flush    = 1'b0;
      bus.Read_Reg = 3'd3;
      bus.Fwd_Reg  = 3'd3;
      tick();
      tick();
      chk("rst_wb_valid", {15'd0, bus.WB_Valid}, 16'h0000);
      chk("rst_wb_data", {8'd0, bus.WB_Write_Data}, 16'h0000);
      chk("rst_read", {8'd0, bus.Read_Data}, 16'h0000);
      chk("rst_fwd_hit", {15'd0, bus.Fwd_Hit}, 16'h0000);
      chk_cnt("rst_cnt", 16'h0000);
      Reset = 1'b0;

      // li r3,0x2A
      ex(1, 1, 3, 8'h2A);
      tick();
      ex(0, 0, 0, 8'h00);
      chk("li_wb_valid", {15'd0, bus.WB_Valid}, 16'h0001);
      chk("li_wb_reg", {13'd0, bus.WB_Write_Reg}, 16'h0003);
      chk("li_bypass", {8'd0, bus.Read_Data}, 16'h002A);
      chk("li_fwd_hit", {15'd0, bus.Fwd_Hit}, 16'h0001);
      tick();
      chk("li_wb_bubble", {15'd0, bus.WB_Valid}, 16'h0000);
      chk("li_array", {8'd0, bus.Read_Data}, 16'h002A);
      chk_cnt("li_cnt", 16'h0001);

      // write to r0 is dropped
      bus.Read_Reg = 3'd0;
      bus.Fwd_Reg  = 3'd0;
      ex(1, 1, 0, 8'h55);
      tick();
      ex(0, 0, 0, 8'h00);
      chk("r0_wb_valid", {15'd0, bus.WB_Valid}, 16'h0001);
      chk("r0_read_wb", {8'd0, bus.Read_Data}, 16'h0000);
      chk("r0_fwd_wb", {15'd0, bus.Fwd_Hit}, 16'h0000);
      tick();
      chk("r0_read_arr", {8'd0, bus.Read_Data}, 16'h0000);
      chk("r0_fwd_arr", {15'd0, bus.Fwd_Hit}, 16'h0000);
      chk_cnt("r0_cnt", 16'h0002);

      // capture r5, then stall three edges while EX offers r6
      ex(1, 1, 5, 8'h10);
      tick();
      bus.Stall    = 1'b1;
      bus.Read_Reg = 3'd5;
      bus.Fwd_Reg  = 3'd5;
      ex(1, 1, 6, 8'h99);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_wb_reg", {13'd0, bus.WB_Write_Reg}, 16'h0005);
         chk("stall_wb_data", {8'd0, bus.WB_Write_Data}, 16'h0010);
         chk_cnt("stall_cnt", 16'h0002);
      end
      chk("stall_fwd_hit", {15'd0, bus.Fwd_Hit}, 16'h0001);
      bus.Read_Reg = 3'd6;
      #1;
      chk("stall_r6_unwritten", {8'd0, bus.Read_Data}, 16'h0000);
      bus.Stall    = 1'b0;
      bus.Read_Reg = 3'd5;
      tick();
      chk("release_wb_reg", {13'd0, bus.WB_Write_Reg}, 16'h0006);
      chk("release_r5", {8'd0, bus.Read_Data}, 16'h0010);
      chk_cnt("release_cnt", 16'h0003);

      // Stall and Flush together: r6 drains, r2 squashed
      bus.Stall = 1'b1;
      bus.Flush = 1'b1;
      ex(1, 1, 2, 8'h77);
      tick();
      bus.Stall = 1'b0;
      bus.Flush = 1'b0;
      ex(0, 0, 0, 8'h00);
      bus.Read_Reg = 3'd6;
      #1;
      chk("flush_bubble", {15'd0, bus.WB_Valid}, 16'h0000);
      chk("flush_r6", {8'd0, bus.Read_Data}, 16'h0099);
      chk_cnt("flush_cnt", 16'h0004);
      bus.Read_Reg = 3'd2;
      tick();
      chk("flush_r2", {8'd0, bus.Read_Data}, 16'h0000);
      chk_cnt("flush_cnt2", 16'h0004);

      // back-to-back r1 writes, bypass beats array
      bus.Read_Reg = 3'd1;
      bus.Fwd_Reg  = 3'd1;
      ex(1, 1, 1, 8'h01);
      tick();
      ex(1, 1, 1, 8'h02);
      chk("b2b_read1", {8'd0, bus.Read_Data}, 16'h0001);
      chk("b2b_hit1", {15'd0, bus.Fwd_Hit}, 16'h0001);
      chk("b2b_fwd1", {8'd0, bus.Fwd_Data}, 16'h0001);
      tick();
      ex(0, 0, 0, 8'h00);
      chk("b2b_read2", {8'd0, bus.Read_Data}, 16'h0002);
      chk("b2b_hit2", {15'd0, bus.Fwd_Hit}, 16'h0001);
      chk("b2b_fwd2", {8'd0, bus.Fwd_Data}, 16'h0002);
      tick();
      chk("b2b_array", {8'd0, bus.Read_Data}, 16'h0002);
      chk("b2b_hit_off", {15'd0, bus.Fwd_Hit}, 16'h0000);
      chk_cnt("b2b_cnt", 16'h0006);

      // asynchronous reset while WB holds r4=0xFF
      bus.Read_Reg = 3'd4;
      bus.Fwd_Reg  = 3'd4;
      ex(1, 1, 4, 8'hFF);
      tick();
      ex(0, 0, 0, 8'h00);
      chk("pre_rst_r4", {8'd0, bus.Read_Data}, 16'h00FF);
      #2;
      Reset = 1'b1;
      #1;
      chk("arst_wb_valid", {15'd0, bus.WB_Valid}, 16'h0000);
      chk("arst_wb_data", {8'd0, bus.WB_Write_Data}, 16'h0000);
      chk("arst_read", {8'd0, bus.Read_Data}, 16'h0000);
      chk("arst_fwd_hit", {15'd0, bus.Fwd_Hit}, 16'h0000);
      chk_cnt("arst_cnt", 16'h0000);
      bus.Read_Reg = 3'd3;
      #1;
      chk("arst_r3", {8'd0, bus.Read_Data}, 16'h0000);
      Reset = 1'b0;
      bus.Read_Reg = 3'd4;
      tick();
      chk("post_rst_r4", {8'd0, bus.Read_Data}, 16'h0000);
      chk_cnt("post_rst_cnt", 16'h0000);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule

// File: doc/ex_wb_regfile.md
Name: ex_wb_regfile

Overview:
- Downstream neighbour of the EX-stage adder (li/addi datapath).
- Latches the EX result into an EX/WB pipeline register, then writes it back into an 8 x 8-bit register file on the following edge.
- Provides a combinational read port with write-through bypass, which feeds the next instruction's ID/EX operand.
- Provides a forwarding tap that lets EX consume the in-flight WB value.

Parameters:
DATA_W, 8, width of register data and EX result
REG_AW, 3, register address width
NUM_REGS, 8, register count (2**REG_AW); r0 hardwired to zero

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high; clears all state
EX_Valid  input  1  EX stage holds a real instruction this cycle
EX_RegWrite  input  1  EX instruction writes a register
EX_Write_Reg  input  REG_AW  destination register of EX instruction
EX_Result  input  DATA_W  EX adder result
Stall  input  1  hold EX/WB latch and suppress writeback this edge
Flush  input  1  squash the EX instruction (latch loads a bubble)
Read_Reg  input  REG_AW  read port address
Read_Data  output  DATA_W  read port data (combinational, bypassed)
Fwd_Reg  input  REG_AW  EX source register for forwarding compare
Fwd_Hit  output  1  WB latch will write Fwd_Reg
Fwd_Data  output  DATA_W  WB latch data for forwarding
WB_Valid  output  1  EX/WB latch valid
WB_Write_Reg  output  REG_AW  latched destination
WB_Write_Data  output  DATA_W  latched result

Behaviour:
- Reset is asynchronous and active-high; the clock is Clk and the reset is Reset.
  - On Reset, all registers r0..r7 go to 0.
  - Latch fields go to 0: WB_Valid=0, WB_Write_Reg=0, WB_Write_Data=0, internal WB_RegWrite=0.
  - Hence Read_Data=0 and Fwd_Hit=0 while Reset is asserted.
  - Reset asserted mid-operation discards the in-flight latch contents; no write occurs.
- Define wb_we = WB_Valid & WB_RegWrite & (WB_Write_Reg != 0).
- Edge priority, evaluated at each rising Clk:
  - Flush=1 (regardless of Stall): the latch loads a bubble (WB_Valid=0, WB_RegWrite=0). Other latch fields load the EX inputs but are don't-care. If wb_we, the register file writes.
  - Stall=1 and Flush=0: the latch holds and the register file is not written.
  - Otherwise: the latch loads WB_Valid<=EX_Valid, WB_RegWrite<=EX_Valid&EX_RegWrite, WB_Write_Reg<=EX_Write_Reg, WB_Write_Data<=EX_Result. If wb_we, regfile[WB_Write_Reg]<=WB_Write_Data.
- Stall applies to the whole pair: a held instruction writes back exactly once, on the first edge with Stall=0 or Flush=1.
- Latency: an EX result presented in cycle N is captured at edge N.
  - In cycle N+1 it is visible on WB_* and through the bypass.
  - It is written at edge N+1 (absent stall).
  - In cycle N+2 it is read directly from the array.
- Read_Data:
  - Read_Reg==0 gives 0.
  - Else, if wb_we and WB_Write_Reg==Read_Reg, gives WB_Write_Data (bypass).
  - Else gives regfile[Read_Reg].
- Fwd_Hit = wb_we & (WB_Write_Reg==Fwd_Reg). Fwd_Data = WB_Write_Data, driven unconditionally.
- Writes to r0 are dropped and never bypassed. Register addresses are exactly REG_AW bits wide, so there is no out-of-range case.
- No arithmetic is performed. Data passes through at full DATA_W with no truncation or extension.

Optional Feature:
- Macro: EX_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output Retire_Cnt [15:0], reset to 0.
  - Increments on every edge where the latch holds a valid instruction that leaves the stage: WB_Valid=1 and (Stall=0 or Flush=1). This includes instructions with RegWrite=0.
  - Saturates at 16'hFFFF and does not wrap.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then li r3,0x2A (EX_Valid=1, RegWrite=1, Write_Reg=3, Result=0x2A) -> cycle+1: WB_Valid=1 and Read_Reg=3 returns 0x2A via bypass. Cycle+2: 0x2A read from the array.
- Write r0=0x55, then read r0 with Fwd_Reg=0 -> Read_Data=0x00, Fwd_Hit=0 at all cycles.
- Capture r5=0x10, then hold Stall=1 for 3 cycles -> WB_* held at 5/0x10 and the array is unwritten (read r5 with bypass source masked by a different latch is still old value 0). After release, r5=0x10 is written exactly once; Retire_Cnt increments by 1.
- Stall=1 and Flush=1 on the same edge with EX r2=0x77 -> the latch becomes a bubble, the pending WB instruction writes, and r2 is never written (stays 0x00).
- Back-to-back r1=0x01, then r1=0x02, then read r1 -> Read_Data shows 0x01 then 0x02 (bypass priority over array); Fwd_Hit=1 with Fwd_Reg=1 in both cycles.
- Assert Reset asynchronously mid-cycle while WB holds r4=0xFF -> outputs clear immediately without waiting for a clock; r4 reads 0x00 afterwards; Retire_Cnt=0.
